// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: per-line sprite renderer; clears the back line-buffer bank,
// scans the sprite table and writes opaque sprite pixels for the target line.
module sprite_line_scheduler #(
  parameter int N_SPRITES = 20,
  parameter int SPRITE_W  = 32,
  parameter int SPRITE_H  = 32,
  parameter int LINE_W    = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  output logic [4:0]  tbl_addr,
  input  logic [23:0] tbl_data,
  output logic [14:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic        lb_we,
  output logic [9:0]  lb_addr,
  output logic [23:0] lb_data,
  output logic        bank,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, CHECK, DRAW, DRAIN, DONE} state_t;
  localparam logic [9:0]  LAST_COL = 10'(LINE_W - 1);
  localparam logic [4:0]  LAST_IDX = 5'(N_SPRITES - 1);
  localparam logic [4:0]  LAST_K   = 5'(SPRITE_W - 1);
  localparam logic [9:0]  SH       = 10'(SPRITE_H);
  localparam logic [10:0] LW       = 11'(LINE_W);
  state_t      state_q, state_d;
  logic        bank_q, bank_d, pend_q, pend_d, ovr_q, ovr_d;
  logic [8:0]  ly_q, ly_d;
  logic [9:0]  col_q, col_d, x_q, x_d;
  logic [4:0]  idx_q, idx_d, typ_q, typ_d, row_q, row_d, pcol_q, pcol_d;
  logic [9:0]  row_full;
  logic [10:0] wsum;
  logic        hit, last, clr, pw;
  assign busy     = !(state_q == IDLE || state_q == DONE);
  assign done     = state_q == DONE;
  assign overrun  = ovr_q;
  assign bank     = bank_q;
  assign tbl_addr = idx_q;
  assign rom_addr = (state_q == DRAW) ? {typ_q, row_q, col_q[4:0]} : 15'd0;
  // pend_q marks a ROM read issued last cycle whose pixel is on rom_data now
  assign clr      = state_q == CLEAR;
  assign wsum     = {1'b0, x_q} + {6'd0, pcol_q};
  assign pw       = pend_q && rom_data != 24'd0 && wsum < LW;
  assign lb_we    = clr || pw;
  assign lb_addr  = clr ? col_q : (pend_q ? wsum[9:0] : 10'd0);
  assign lb_data  = pw ? rom_data : 24'd0;
  always_comb begin
    row_full = {1'b0, ly_q} - {1'b0, tbl_data[13:5]};
    hit      = tbl_data[4:0] != 5'd0 && ly_q >= tbl_data[13:5] && row_full < SH;
    last     = idx_q == LAST_IDX;
    state_d  = state_q;
    bank_d   = bank_q;
    ly_d     = ly_q;
    col_d    = col_q;
    idx_d    = idx_q;
    x_d      = x_q;
    typ_d    = typ_q;
    row_d    = row_q;
    pend_d   = 1'b0;
    pcol_d   = col_q[4:0];
    ovr_d    = 1'b0;
    if (line_start) begin
      ly_d    = line_y;
      bank_d  = ~bank_q;
      state_d = CLEAR;
      col_d   = 10'd0;
      ovr_d   = busy;
    end else begin
      case (state_q)
        CLEAR: begin
          col_d = col_q + 10'd1;
          if (col_q == LAST_COL) begin
            state_d = FETCH;
            idx_d   = 5'd0;
          end
        end
        FETCH: state_d = CHECK;
        CHECK: begin
          if (hit) begin
            x_d     = tbl_data[23:14];
            typ_d   = tbl_data[4:0];
            row_d   = row_full[4:0];
            col_d   = 10'd0;
            state_d = DRAW;
          end else begin
            state_d = last ? DONE : FETCH;
            idx_d   = last ? idx_q : idx_q + 5'd1;
          end
        end
        DRAW: begin
          pend_d  = 1'b1;
          col_d   = col_q + 10'd1;
          state_d = (col_q[4:0] == LAST_K) ? DRAIN : DRAW;
        end
        DRAIN: begin
          state_d = last ? DONE : FETCH;
          idx_d   = last ? idx_q : idx_q + 5'd1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bank_q  <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      ly_q    <= 9'd0;
      col_q   <= 10'd0;
      x_q     <= 10'd0;
      idx_q   <= 5'd0;
      typ_q   <= 5'd0;
      row_q   <= 5'd0;
      pcol_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      ly_q    <= ly_d;
      col_q   <= col_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
      typ_q   <= typ_d;
      row_q   <= row_d;
      pcol_q  <= pcol_d;
    end
  end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: directed vectors, random tables and corner sequences,
// each line checked against a write-list model built from the sprite table.
module tb_sprite_line_scheduler;
  logic        clk = 1'b0, reset = 1'b0, line_start = 1'b0;
  logic [8:0]  line_y = 9'd0;
  logic [4:0]  tbl_addr;
  logic [23:0] tbl_data = 24'd0, rom_data = 24'd0;
  logic [14:0] rom_addr;
  logic        lb_we, bank, busy, done, overrun;
  logic [9:0]  lb_addr;
  logic [23:0] lb_data;
  logic [23:0] tbl [20];
  int          rom_mode = 0;
  int          total = 0, bad = 0;
  logic        exp_bank = 1'b0;
  typedef struct {logic [9:0] a; logic [23:0] d; int c;} wr_t;
  typedef struct {string nm; int ly; int mode; int ent; int x; int y; int typ; int e_done; int e_nw;} vec_t;

  sprite_line_scheduler dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .rom_addr(rom_addr), .rom_data(rom_data),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data), .bank(bank),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_fn(input logic [14:0] a);
    logic [31:0] h;
    h = {17'd0, a} * 32'h9E3779B1;
    if (rom_mode == 0) return 24'hFF0000;
    if (rom_mode == 1) return a[0] ? 24'h0 : 24'hFF0000;
    return (a[2:0] == 3'd5) ? 24'h0 : (h[31:8] | 24'h1);
  endfunction

  always @(posedge clk) begin
    rom_data <= rom_fn(rom_addr);
    tbl_data <= (int'(tbl_addr) < 20) ? tbl[tbl_addr] : 24'h0;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_one(input int ent, input int x, input int y, input int typ);
    for (int i = 0; i < 20; i++) tbl[i] = 24'h0;
    tbl[ent] = {10'(x), 9'(y), 5'(typ)};
  endtask

  task automatic run_line(input string nm, input int ly, input int ovr_exp, output int dcyc, output int nw);
    wr_t exp_q[$], act_q[$];
    logic [14:0] erom[$], arom[$];
    int t, ex, ey, et, row, ovr_n, bi, n;
    logic [23:0] d;
    for (int c = 0; c < 640; c++) exp_q.push_back('{10'(c), 24'h0, c + 1});
    t = 641;
    for (int i = 0; i < 20; i++) begin
      ex = int'(tbl[i][23:14]);
      ey = int'(tbl[i][13:5]);
      et = int'(tbl[i][4:0]);
      t += 2;
      if (et != 0 && ly >= ey && ly - ey < 32) begin
        row = ly - ey;
        for (int k = 0; k < 32; k++) begin
          erom.push_back(15'(et * 1024 + row * 32 + k));
          d = rom_fn(15'(et * 1024 + row * 32 + k));
          if (d != 24'h0 && ex + k < 640) exp_q.push_back('{10'(ex + k), d, t + k + 1});
        end
        t += 33;
      end
    end
    @(negedge clk);
    line_start = 1'b1;
    line_y = 9'(ly);
    exp_bank = ~exp_bank;
    dcyc = -1;
    ovr_n = 0;
    for (int c = 1; c <= 3000 && dcyc < 0; c++) begin
      @(negedge clk);
      line_start = 1'b0;
      if (lb_we) act_q.push_back('{lb_addr, lb_data, c});
      if (rom_addr != 15'd0) arom.push_back(rom_addr);
      ovr_n += int'(overrun);
      if (done) dcyc = c;
    end
    nw = act_q.size() - 640;
    chk({nm, ".done_cycle"}, dcyc, t);
    chk({nm, ".bank"}, bank, exp_bank);
    chk({nm, ".overrun_pulses"}, ovr_n, ovr_exp);
    chk({nm, ".write_count"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    bi = -1;
    for (int i = 0; i < n; i++)
      if (bi < 0 && (act_q[i].a != exp_q[i].a || act_q[i].d != exp_q[i].d || act_q[i].c != exp_q[i].c)) bi = i;
    chk({nm, ".first_bad_write"}, bi, -1);
    if (bi >= 0)
      $display("  %s write %0d: addr=%0d data=%h cyc=%0d, model addr=%0d data=%h cyc=%0d", nm, bi,
               act_q[bi].a, act_q[bi].d, act_q[bi].c, exp_q[bi].a, exp_q[bi].d, exp_q[bi].c);
    chk({nm, ".rom_count"}, arom.size(), erom.size());
    n = (arom.size() < erom.size()) ? arom.size() : erom.size();
    bi = -1;
    for (int i = 0; i < n; i++) if (bi < 0 && arom[i] != erom[i]) bi = i;
    chk({nm, ".first_bad_rom_addr"}, bi, -1);
  endtask

  vec_t vecs[8];
  int   dc, nw, ly, ty, yy, nwe, nb;

  initial begin
    vecs[0] = '{"blank",      10, 0, 0,   0,  0,  0, 681,  0};
    vecs[1] = '{"solid",      52, 0, 3, 100, 50,  3, 714, 32};
    vecs[2] = '{"odd_clear",  52, 1, 3, 100, 50,  3, 714, 16};
    vecs[3] = '{"right_clip", 31, 0, 0, 620,  0,  1, 714, 20};
    vecs[4] = '{"below",      32, 0, 0, 620,  0,  1, 681,  0};
    vecs[5] = '{"above",      49, 0, 3, 100, 50,  3, 681,  0};
    vecs[6] = '{"last_row",   81, 0, 19,  0, 50, 31, 714, 32};
    vecs[7] = '{"x_off",      60, 0, 5, 640, 60,  2, 714,  0};
    for (int i = 0; i < 20; i++) tbl[i] = 24'h0;
    #1 reset = 1'b1;
    #2 chk("reset.outputs", {busy, done, overrun, bank, lb_we, lb_addr, lb_data, tbl_addr, rom_addr}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    nwe = 0;
    repeat (5) begin
      @(negedge clk);
      nwe += int'(lb_we) + int'(busy) + int'(done);
    end
    chk("idle.quiet", nwe, 0);

    foreach (vecs[v]) begin
      set_one(vecs[v].ent, vecs[v].x, vecs[v].y, vecs[v].typ);
      rom_mode = vecs[v].mode;
      run_line(vecs[v].nm, vecs[v].ly, 0, dc, nw);
      chk({vecs[v].nm, ".spec_done"}, dc, vecs[v].e_done);
      chk({vecs[v].nm, ".spec_sprite_writes"}, nw, vecs[v].e_nw);
    end

    rom_mode = 2;
    for (int r = 0; r < 6; r++) begin
      ly = $urandom_range(40, 479);
      for (int i = 0; i < 20; i++) begin
        ty = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
        yy = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 511) : ly - $urandom_range(0, 36);
        tbl[i] = {10'($urandom_range(0, 1023)), 9'(yy), 5'(ty)};
      end
      run_line($sformatf("rnd%0d", r), ly, 0, dc, nw);
    end

    // new line_start lands in the middle of a DRAW
    set_one(3, 100, 50, 3);
    rom_mode = 0;
    @(negedge clk);
    line_start = 1'b1;
    line_y = 9'd52;
    exp_bank = ~exp_bank;
    @(negedge clk);
    line_start = 1'b0;
    repeat (655) @(negedge clk);
    chk("ovr.in_draw", rom_addr != 15'd0, 1);
    run_line("ovr", 90, 1, dc, nw);

    // asynchronous reset in the middle of a DRAW
    @(negedge clk);
    line_start = 1'b1;
    line_y = 9'd52;
    @(negedge clk);
    line_start = 1'b0;
    for (int c = 0; c < 2000 && rom_addr == 15'd0; c++) @(negedge clk);
    chk("rst.reached_draw", rom_addr != 15'd0, 1);
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("rst.async_outputs", {busy, done, overrun, bank, lb_we, lb_addr, lb_data, tbl_addr, rom_addr}, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_bank = 1'b0;
    nwe = 0;
    nb = 0;
    repeat (40) begin
      @(negedge clk);
      nwe += int'(lb_we);
      nb += int'(busy) + int'(done) + int'(bank) + int'(overrun);
    end
    chk("rst.no_writes", nwe, 0);
    chk("rst.idle_flags", nb, 0);
    run_line("post_rst", 52, 0, dc, nw);
    chk("post_rst.sprite_writes", nw, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
